// File: rtl/test_source_pkg.sv
// Shared types and constants for the val/rdy test source and its optional
// random-delay LFSR.
package test_source_pkg;

  typedef enum logic [1:0] {
    INIT,
    WAIT,
    SEND,
    DONE
  } state_t;

  localparam int              lfsr_width   = 16;
  // Galois form of x^16 + x^14 + x^13 + x^11 + 1, shifting right.
  localparam logic [15:0]     lfsr_taps    = 16'hB400;
  localparam logic [15:0]     default_seed = 16'hACE1;

endpackage

// File: rtl/test_source_lfsr.sv
// 16-bit Galois LFSR that supplies pseudo-random inter-message delays.
// It steps only when en is high and reloads the seed on reset.
module test_source_lfsr
  import test_source_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [lfsr_width-1:0] seed,
  output logic [lfsr_width-1:0] out
);

  // NOTE: flops use non-blocking assignment so that every register samples the
  // values from before the edge, whatever order the blocks are evaluated in.
  always_ff @(posedge clk) begin
    if (reset) begin
      out <= seed;
    end else if (en) begin
      out <= {1'b0, out[lfsr_width-1:1]} ^ (out[0] ? lfsr_taps : '0);
    end
  end

endmodule

// File: rtl/test_source.sv
// Test source: sends p_nmsgs preloaded messages on a val/rdy channel and then
// raises done. Define TEST_SOURCE_RAND_DELAY_EN for LFSR-driven random gaps.
module test_source
  import test_source_pkg::*;
#(
  parameter int                    p_width       = 16,
  parameter int                    p_nmsgs       = 4,
  parameter int                    p_max_delay   = 0,
  parameter logic [lfsr_width-1:0] p_seed        = default_seed,
  parameter int                    p_nmsgs_width = $clog2(p_nmsgs + 1)
) (
  input  logic               clk,
  input  logic               reset,
  output logic               val,
  input  logic               rdy,
  output logic [p_width-1:0] msg,
  output logic               done
);

  localparam int idx_w     = (p_nmsgs_width > 0) ? p_nmsgs_width : 1;
  localparam int mem_depth = (p_nmsgs > 0) ? p_nmsgs : 1;
  localparam int addr_w    = (mem_depth > 1) ? $clog2(mem_depth) : 1;
  localparam int cnt_w     = (p_max_delay > 0) ? $clog2(p_max_delay + 1) : 1;
  localparam logic [idx_w-1:0] last_idx = idx_w'(p_nmsgs - 1);

  // NOTE: the message store is written only by the enclosing bench, so it has
  // no reset; clearing it would destroy the preloaded sequence.
  logic [p_width-1:0] mem [mem_depth-1:0];

  state_t             state;
  logic [idx_w-1:0]   idx;
  logic [cnt_w-1:0]   cnt;
  logic [cnt_w-1:0]   delay;
  logic [addr_w-1:0]  rd_addr;

`ifdef TEST_SOURCE_RAND_DELAY_EN
  logic                  load_en;
  logic [lfsr_width-1:0] lfsr_out;

  // A new delay is drawn on INIT exit and after every non-final handshake.
  assign load_en = ((state == INIT) && (p_nmsgs != 0)) ||
                   ((state == SEND) && rdy && (idx != last_idx));

  test_source_lfsr u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (load_en),
    .seed  (p_seed),
    .out   (lfsr_out)
  );

  assign delay = cnt_w'(lfsr_out % lfsr_width'(p_max_delay + 1));
`else
  assign delay = cnt_w'(p_max_delay);
`endif

  assign rd_addr = idx[addr_w-1:0];

  // NOTE: every path assigns msg, so this block cannot infer a latch.
  always_comb begin
    msg = '0;
    if (state != DONE) msg = mem[rd_addr];
  end

  // val and done are registered alongside the state, so rdy never reaches val
  // combinationally.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INIT;
      idx   <= '0;
      cnt   <= '0;
      val   <= 1'b0;
      done  <= 1'b0;
    end else begin
      unique case (state)
        INIT: begin
          if (p_nmsgs == 0) begin
            state <= DONE;
            done  <= 1'b1;
          end else if (delay == '0) begin
            state <= SEND;
            val   <= 1'b1;
          end else begin
            state <= WAIT;
            cnt   <= delay;
          end
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == cnt_w'(1)) begin
            state <= SEND;
            val   <= 1'b1;
          end
        end
        SEND: begin
          if (rdy) begin
            idx <= idx + 1'b1;
            if (idx == last_idx) begin
              state <= DONE;
              val   <= 1'b0;
              done  <= 1'b1;
            end else if (delay != '0) begin
              state <= WAIT;
              cnt   <= delay;
              val   <= 1'b0;
            end
          end
        end
        DONE: begin
          state <= DONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_test_source.sv
// Self-checking bench for test_source: stream, backpressure, reset mid-run,
// fixed delay and empty-sequence cases, checked against a message scoreboard.
module tb_test_source;
  import test_source_pkg::*;

  localparam int w = 16;
  localparam logic [w-1:0] seq [4] = '{16'd5, 16'd2, 16'd18, 16'd3};

  typedef struct {
    logic         rdy;
    logic         val;
    logic [w-1:0] msg;
    logic         done;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         rdy_a = 1'b0;
  logic         rdy_b = 1'b1;
  logic         rdy_c = 1'b1;
  logic         val_a, val_b, val_c;
  logic         done_a, done_b, done_c;
  logic [w-1:0] msg_a, msg_b, msg_c;

  vec_t         vec_q[$];
  logic [w-1:0] sb_a[$];
  logic [w-1:0] sb_b[$];
  int           checks = 0;
  int           failures = 0;
  bit           verbose = 1'b1;

  always #5 clk = ~clk;

  test_source #(.p_width(w), .p_nmsgs(4), .p_max_delay(0)) u_a (
    .clk(clk), .reset(reset), .val(val_a), .rdy(rdy_a), .msg(msg_a), .done(done_a)
  );
  test_source #(.p_width(w), .p_nmsgs(4), .p_max_delay(2)) u_b (
    .clk(clk), .reset(reset), .val(val_b), .rdy(rdy_b), .msg(msg_b), .done(done_b)
  );
  test_source #(.p_width(w), .p_nmsgs(0), .p_max_delay(0)) u_c (
    .clk(clk), .reset(reset), .val(val_c), .rdy(rdy_c), .msg(msg_c), .done(done_c)
  );

  always @(posedge clk) begin
    if (verbose && !reset && val_a && rdy_a)
      $display("%d: [ sent ] Entry %d (0x%h)", $time, u_a.idx, msg_a);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pop(input string name, input bit which, input logic [w-1:0] act);
    logic [w-1:0] e;
    if ((which ? sb_b.size() : sb_a.size()) == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: unexpected handshake with msg %0h", name, act);
    end else begin
      e = which ? sb_b.pop_front() : sb_a.pop_front();
      check(name, act, e);
    end
  endtask

  // One reset cycle; expected messages are queued as the sequence is restarted.
  task automatic do_reset();
    reset = 1'b1;
    step();
    check("rst_val", val_a, 1'b0);
    check("rst_done", done_a, 1'b0);
    check("rst_msg", msg_a, seq[0]);
    sb_a.delete();
    sb_b.delete();
    for (int i = 0; i < 4; i++) begin
      sb_a.push_back(seq[i]);
      sb_b.push_back(seq[i]);
    end
    reset = 1'b0;
  endtask

  task automatic add_vec(input logic r, input logic v, input logic [w-1:0] m, input logic d);
    vec_q.push_back('{rdy: r, val: v, msg: m, done: d});
  endtask

  task automatic run_vectors(input string name);
    foreach (vec_q[i]) begin
      rdy_a = vec_q[i].rdy;
      check($sformatf("%s_val%0d", name, i), val_a, vec_q[i].val);
      check($sformatf("%s_done%0d", name, i), done_a, vec_q[i].done);
      check($sformatf("%s_msg%0d", name, i), msg_a, vec_q[i].msg);
      if (val_a && rdy_a) pop($sformatf("%s_hs%0d", name, i), 1'b0, msg_a);
      step();
    end
    check($sformatf("%s_left", name), sb_a.size(), 0);
    vec_q.delete();
  endtask

  task automatic run_until_done_a(input string name, input int budget);
    int n = 0;
    rdy_a = 1'b1;
    while (!done_a && n < budget) begin
      if (val_a) pop($sformatf("%s_hs", name), 1'b0, msg_a);
      step();
      n++;
    end
    check($sformatf("%s_done", name), done_a, 1'b1);
    check($sformatf("%s_left", name), sb_a.size(), 0);
    check($sformatf("%s_val_after", name), val_a, 1'b0);
  endtask

  // Runs the delayed source and returns its val trace, one bit per cycle.
  task automatic run_b(input string name, output logic [31:0] trace);
    int last = 0;
    trace = '0;
    for (int c = 0; c < 24; c++) begin
      trace[c] = val_b;
`ifdef TEST_SOURCE_RAND_DELAY_EN
      if (val_b) begin
        check($sformatf("%s_gap%0d", name, c), (c - last - 1) <= 2, 1'b1);
        last = c;
      end
`else
      check($sformatf("%s_val%0d", name, c), val_b, (c == 3 || c == 6 || c == 9 || c == 12));
      check($sformatf("%s_done%0d", name, c), done_b, c >= 13);
`endif
      if (val_b) pop($sformatf("%s_hs%0d", name, c), 1'b1, msg_b);
      step();
    end
    check($sformatf("%s_left", name), sb_b.size(), 0);
    check($sformatf("%s_end_done", name), done_b, 1'b1);
  endtask

  initial begin
    logic [31:0] trace1, trace2;
    for (int i = 0; i < 4; i++) begin
      u_a.mem[i] = seq[i];
      u_b.mem[i] = seq[i];
    end

    // Back-to-back stream with rdy always high.
    do_reset();
    add_vec(1, 0, 5, 0);  add_vec(1, 1, 5, 0);  add_vec(1, 1, 2, 0);
    add_vec(1, 1, 18, 0); add_vec(1, 1, 3, 0);  add_vec(1, 0, 0, 1);
    add_vec(1, 0, 0, 1);
    run_vectors("stream");

    // rdy low during the 2nd and 3rd cycles of val: message 2 must hold.
    do_reset();
    add_vec(1, 0, 5, 0);  add_vec(1, 1, 5, 0);  add_vec(0, 1, 2, 0);
    add_vec(0, 1, 2, 0);  add_vec(1, 1, 2, 0);  add_vec(1, 1, 18, 0);
    add_vec(1, 1, 3, 0);  add_vec(1, 0, 0, 1);  add_vec(1, 0, 0, 1);
    run_vectors("bp");

    // Reset after two handshakes; the sequence restarts from the first entry.
    do_reset();
    rdy_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (val_a) pop("mid_hs", 1'b0, msg_a);
      step();
    end
    check("mid_pre_msg", msg_a, seq[2]);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_val", val_a, 1'b0);
    check("mid_rst_done", done_a, 1'b0);
    check("mid_rst_msg", msg_a, seq[0]);
    sb_a.delete();
    for (int i = 0; i < 4; i++) sb_a.push_back(seq[i]);
    run_until_done_a("mid_restart", 20);

    // Delayed source, repeated to confirm the trace is reproducible.
    do_reset();
    run_b("dly1", trace1);
`ifdef TEST_SOURCE_RAND_DELAY_EN
    do_reset();
    run_b("dly2", trace2);
    check("dly_repeat", trace2, trace1);
`else
    trace2 = trace1;
`endif

    // Empty sequence: done one cycle after release, val never asserted.
    do_reset();
    for (int c = 0; c < 6; c++) begin
      check($sformatf("empty_val%0d", c), val_c, 1'b0);
      check($sformatf("empty_done%0d", c), done_c, c >= 1);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timed out");
  end

endmodule
